// File: rtl/data_memory_if.sv
// Memory-side line bus between the data cache (master) and the data memory model (slave).
// One request per transaction; the master holds enable_i until it observes ack_o.
interface data_memory_if;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;

  modport master (
    output addr_i,
    output data_i,
    output enable_i,
    output write_i,
    input  ack_o,
    input  data_o
  );

  modport slave (
    input  addr_i,
    input  data_i,
    input  enable_i,
    input  write_i,
    output ack_o,
    output data_o
  );
endinterface

// File: rtl/data_memory.sv
// Off-chip data memory model: one 256-bit line read/write per transaction, completed
// with a single-cycle ack a fixed LATENCY edges after acceptance.
module data_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic          clk_i,
  input  logic          rst_i,
  data_memory_if.slave  bus
);
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [7:0]  LAT   = 8'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t             state_reg, state_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg;
  logic [255:0]       wdata_reg;
  logic               write_reg;
  logic [255:0]       data_reg;
  logic               latch_en;
  logic               commit;

  logic [255:0] mem [DEPTH];

  // Offset bits and everything above the index are don't-care: the space wraps.
  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:5+IDX_W], bus.addr_i[4:0]};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch_en   = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.enable_i) begin
          state_next = ST_WAIT;
          cnt_next   = 8'd1;
          latch_en   = 1'b1;
        end
      end
      ST_WAIT: begin
        // cnt equals the number of edges since acceptance, so the access lands on edge E0+LATENCY.
        if (cnt_reg == LAT) begin
          state_next = ST_ACK;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (latch_en && !rst_i) begin
      idx_reg   <= bus.addr_i[5 +: IDX_W];
      wdata_reg <= bus.data_i;
      write_reg <= bus.write_i;
    end
  end

  // Array has no reset so it maps onto block RAM; reset only suppresses an in-flight write.
  always_ff @(posedge clk_i) begin
    if (commit && write_reg && !rst_i) begin
      mem[idx_reg] <= wdata_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_reg <= '0;
    end else if (commit && !write_reg) begin
      data_reg <= mem[idx_reg];
    end
  end

  assign bus.ack_o  = (state_reg == ST_ACK);
  assign bus.data_o = data_reg;
endmodule
